// File: rtl/hash_seq_pkg.sv
// hash_seq_pkg: shared definitions for the block-hash sequencer.
//   state_e           - sequencer FSM states
//   DEF_SUM_HOLD_MASK - default reg_en bits held low during ACCUM
//   cnt_w()           - width of a counter able to hold 0..max_blocks
package hash_seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FETCH,
    ST_ISSUE,
    ST_WAIT,
    ST_ACCUM,
    ST_CHECK,
    ST_DONE,
    ST_ERR
  } state_e;

  localparam logic [3:0] DEF_SUM_HOLD_MASK = 4'b0101;

  function automatic int cnt_w(input int max_blocks);
    return $clog2(max_blocks + 1);
  endfunction

endpackage

// File: rtl/hash_seq_wdog.sv
// hash_seq_wdog: core-wait watchdog for hash_seq_ctrl.
// Only compiled when HASH_SEQ_TIMEOUT_EN is defined, so the default build
// carries no stray top-level module.
//   clk_i    - clock
//   rst_ni   - asynchronous active-low reset
//   wait_i   - sequencer is in its core-wait state
//   expire_o - high in the TIMEOUT_CYC-th consecutive wait cycle
`ifdef HASH_SEQ_TIMEOUT_EN
module hash_seq_wdog #(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic wait_i,
  output logic expire_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Any cycle outside WAIT clears the count, so each entry starts from zero.
  always_comb begin
    cnt_d = '0;
    if (wait_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign expire_o = wait_i && (cnt_q == CW'(TIMEOUT_CYC - 1));

endmodule
`endif

// File: rtl/hash_seq_ctrl.sv
// hash_seq_ctrl: sequences a block-hash core over 1..MAX_BLOCKS blocks.
// Per block: fetch handshake, core init/next launch, wait for core_ready,
// accumulate, then loop or finish. All outputs decode from flops only.
// Optional macro HASH_SEQ_TIMEOUT_EN adds a core-wait watchdog (ERR state).
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   start, abort               - job request / cancel
//   num_blocks                 - block count (0 -> 1, >MAX_BLOCKS saturates)
//   fetch_req/fetch_idx/fetch_done - per-block fetch handshake
//   core_init/core_next/core_work_factor/core_ready - core handshake
//   acc_clr, acc_en, reg_en    - datapath controls
//   busy, done, err            - status
module hash_seq_ctrl
  import hash_seq_pkg::*;
#(
  parameter int                   MAX_BLOCKS    = 8,
  parameter int                   NUM_REGS      = 4,
  parameter logic [NUM_REGS-1:0]  SUM_HOLD_MASK = DEF_SUM_HOLD_MASK,
  parameter int unsigned          TIMEOUT_CYC   = 1024,
  parameter int                   CNT_W         = cnt_w(MAX_BLOCKS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [CNT_W-1:0]    num_blocks,
  output logic                fetch_req,
  output logic [CNT_W-1:0]    fetch_idx,
  input  logic                fetch_done,
  output logic                core_init,
  output logic                core_next,
  output logic                core_work_factor,
  input  logic                core_ready,
  output logic                acc_clr,
  output logic                acc_en,
  output logic [NUM_REGS-1:0] reg_en,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam logic [CNT_W-1:0] MAX_B = CNT_W'(MAX_BLOCKS);
  localparam logic [CNT_W-1:0] ONE_B = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] blk_q, blk_d;
  logic [CNT_W-1:0] n_lat_q, n_lat_d;
  logic [CNT_W-1:0] num_eff;
  logic [CNT_W:0]   blk_inc;
  logic             wd_expire;

`ifdef HASH_SEQ_TIMEOUT_EN
  hash_seq_wdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wdog (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .wait_i   (state_q == ST_WAIT),
    .expire_o (wd_expire)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
  assign wd_expire      = 1'b0;
`endif

  always_comb begin
    num_eff = num_blocks;
    if (num_blocks == '0)        num_eff = ONE_B;
    else if (num_blocks > MAX_B) num_eff = MAX_B;
  end

  // One extra bit so blk+1 never wraps before the compare.
  assign blk_inc = {1'b0, blk_q} + 1'b1;

  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    n_lat_d = n_lat_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_ERR: begin
          if (start) begin
            n_lat_d = num_eff;
            blk_d   = '0;
            state_d = ST_CLEAR;
          end
        end
        ST_CLEAR: state_d = ST_FETCH;
        ST_FETCH: if (fetch_done) state_d = ST_ISSUE;
        ST_ISSUE: state_d = ST_WAIT;
        ST_WAIT: begin
          if (core_ready)     state_d = ST_ACCUM;
          else if (wd_expire) state_d = ST_ERR;
        end
        ST_ACCUM: state_d = ST_CHECK;
        ST_CHECK: begin
          if (blk_inc < {1'b0, n_lat_q}) begin
            blk_d   = blk_inc[CNT_W-1:0];
            state_d = ST_FETCH;
          end else begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      blk_q   <= '0;
      n_lat_q <= '0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      n_lat_q <= n_lat_d;
    end
  end

  always_comb begin
    fetch_req        = 1'b0;
    fetch_idx        = '0;
    core_init        = 1'b0;
    core_next        = 1'b0;
    core_work_factor = 1'b0;
    acc_clr          = 1'b0;
    acc_en           = 1'b0;
    reg_en           = '0;
    busy             = 1'b0;
    done             = 1'b0;
    err              = 1'b0;
    unique case (state_q)
      ST_IDLE: ;
      ST_ERR: begin
`ifdef HASH_SEQ_TIMEOUT_EN
        err = 1'b1;
`endif
      end
      default: begin
        busy      = 1'b1;
        fetch_idx = blk_q;
        reg_en    = '1;
        unique case (state_q)
          ST_CLEAR: acc_clr = 1'b1;
          ST_FETCH: fetch_req = 1'b1;
          ST_ISSUE: begin
            if (blk_q == '0) begin
              core_init = 1'b1;
            end else begin
              core_next        = 1'b1;
              core_work_factor = 1'b1;
            end
          end
          ST_ACCUM: begin
            acc_en = 1'b1;
            reg_en = ~SUM_HOLD_MASK;
          end
          ST_DONE: done = 1'b1;
          default: ;
        endcase
      end
    endcase
  end

endmodule

// File: tb/tb_hash_seq_ctrl.sv
// tb_hash_seq_ctrl: self-checking bench for hash_seq_ctrl.
// Expected per-cycle output vectors are generated from the job timeline
// (CLEAR, then per block FETCH x(F+1), ISSUE, WAIT x(R+1), ACCUM, CHECK,
// then DONE) and compared every cycle; literal checks pin key cycle numbers.
// Define HASH_SEQ_TIMEOUT_EN to also exercise the watchdog (TIMEOUT_CYC=16).
module tb_hash_seq_ctrl;

  localparam int MAXB = 8;
  localparam int CW   = 4;
`ifdef HASH_SEQ_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 0;
`endif

  typedef struct packed {
    logic       fr;
    logic [3:0] idx;
    logic       ci;
    logic       cn;
    logic       wf;
    logic       clr;
    logic       en;
    logic [3:0] re;
    logic       busy;
    logic       done;
    logic       err;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] num_blocks = '0;
  logic          fetch_done = 1'b0;
  logic          core_ready = 1'b0;
  logic          fetch_req, core_init, core_next, core_work_factor;
  logic          acc_clr, acc_en, busy, done, err;
  logic [CW-1:0] fetch_idx;
  logic [3:0]    reg_en;

  hash_seq_ctrl #(
    .MAX_BLOCKS    (MAXB),
    .NUM_REGS      (4),
    .SUM_HOLD_MASK (4'b0101),
    .TIMEOUT_CYC   ((TMO == 0) ? 1024 : TMO)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .abort            (abort),
    .num_blocks       (num_blocks),
    .fetch_req        (fetch_req),
    .fetch_idx        (fetch_idx),
    .fetch_done       (fetch_done),
    .core_init        (core_init),
    .core_next        (core_next),
    .core_work_factor (core_work_factor),
    .core_ready       (core_ready),
    .acc_clr          (acc_clr),
    .acc_en           (acc_en),
    .reg_en           (reg_en),
    .busy             (busy),
    .done             (done),
    .err              (err)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_err = 0;
  int   cyc = 0;
  vec_t exp_q[$];
  vec_t dflt = '0;
  int   f_lat = 0;
  int   r_lat = 0;

  int   n_init = 0, n_next = 0, n_acc = 0, n_done = 0, n_badre = 0;
  int   last_done = 0, last_clr = 0;
  int   idx_log[$];

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  function automatic vec_t actual();
    vec_t v;
    v.fr = fetch_req;  v.idx = fetch_idx; v.ci = core_init; v.cn = core_next;
    v.wf = core_work_factor; v.clr = acc_clr; v.en = acc_en; v.re = reg_en;
    v.busy = busy; v.done = done; v.err = err;
    return v;
  endfunction

  function automatic vec_t busyv(input int k);
    vec_t v = '0;
    v.busy = 1'b1;
    v.re   = 4'hF;
    v.idx  = 4'(k);
    return v;
  endfunction

  // Timeline of one job given fetch wait F and core wait R cycles per block.
  task automatic push_job(input int nb, input int f, input int r);
    int   n;
    int   w;
    vec_t v;
    n = (nb == 0) ? 1 : ((nb > MAXB) ? MAXB : nb);
    v = busyv(0); v.clr = 1'b1; exp_q.push_back(v);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i <= f; i++) begin
        v = busyv(k); v.fr = 1'b1; exp_q.push_back(v);
      end
      v = busyv(k);
      if (k == 0) v.ci = 1'b1;
      else begin v.cn = 1'b1; v.wf = 1'b1; end
      exp_q.push_back(v);
      w = r + 1;
      if (TMO != 0 && w > TMO) begin
        for (int i = 0; i < TMO; i++) exp_q.push_back(busyv(k));
        v = '0; v.err = 1'b1;
        dflt = v;
        return;
      end
      for (int i = 0; i < w; i++) exp_q.push_back(busyv(k));
      v = busyv(k); v.en = 1'b1; v.re = 4'b1010; exp_q.push_back(v);
      exp_q.push_back(busyv(k));
    end
    v = busyv(n - 1); v.done = 1'b1; exp_q.push_back(v);
  endtask

  // Single compare process: one check per cycle, plus event tallies.
  initial begin
    vec_t e;
    vec_t a;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : dflt;
      a = actual();
      check("cycle_vec", 32'(a), 32'(e));
      if (core_init) n_init++;
      if (core_next) n_next++;
      if (core_init || core_next) idx_log.push_back(int'(fetch_idx));
      if (acc_en) begin
        n_acc++;
        if (reg_en != 4'b1010) n_badre++;
      end
      if (acc_clr) last_clr = cyc;
      if (done) begin
        n_done++;
        last_done = cyc;
      end
    end
  end

  // Fetch unit and core models: fixed latencies f_lat / r_lat.
  initial begin
    int fcnt = 0;
    int rcnt = 0;
    bit armed = 1'b0;
    forever begin
      @(negedge clk);
      if (fetch_req) begin
        fetch_done = (fcnt == f_lat);
        fcnt++;
      end else begin
        fetch_done = 1'b0;
        fcnt = 0;
      end
      if (core_init || core_next) begin
        armed = 1'b1;
        rcnt = 0;
        core_ready = 1'b0;
      end else if (armed) begin
        core_ready = (rcnt == r_lat);
        if (core_ready) armed = 1'b0;
        rcnt++;
      end else begin
        core_ready = 1'b0;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_job(input int nb, input int f, input int r, output int s);
    f_lat = f;
    r_lat = r;
    num_blocks = CW'(nb);
    start = 1'b1;
    s = cyc;
    dflt = '0;
    push_job(nb, f, r);
    tick();
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 1000; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    tick();
    tick();
  endtask

  initial begin
    int s;
    int b_init, b_next, b_acc, b_done, b_bad;
    #1;
    check("reset_outputs", 32'(actual()), 0);
    tick(); tick(); tick();
    rst_n = 1'b1;
    tick();

    // n=1, immediate fetch and core
    b_init = n_init; b_next = n_next; b_done = n_done;
    start_job(1, 0, 0, s);
    drain();
    check("n1_clr_cycle", last_clr - s, 1);
    check("n1_done_cycle", last_done - s, 7);
    check("n1_init", n_init - b_init, 1);
    check("n1_next", n_next - b_next, 0);
    check("n1_done_cnt", n_done - b_done, 1);

    // n=8, fetch latency 3, core latency 10
    b_init = n_init; b_next = n_next; b_done = n_done; b_acc = n_acc; b_bad = n_badre;
    idx_log.delete();
    start_job(8, 3, 10, s);
    drain();
    check("n8_init", n_init - b_init, 1);
    check("n8_next", n_next - b_next, 7);
    check("n8_acc", n_acc - b_acc, 8);
    check("n8_reg_en_accum", n_badre - b_bad, 0);
    check("n8_done_cnt", n_done - b_done, 1);
    check("n8_idx_count", idx_log.size(), 8);
    for (int k = 0; k < idx_log.size() && k < 8; k++) check("n8_fetch_idx", idx_log[k], k);

    // num_blocks=0 behaves as 1
    b_init = n_init; b_next = n_next;
    start_job(0, 1, 2, s);
    drain();
    check("n0_pulses", (n_init - b_init) + (n_next - b_next), 1);

    // num_blocks=15 saturates to 8; zero-wait done lands at cycle 42
    b_init = n_init; b_next = n_next;
    start_job(15, 0, 0, s);
    drain();
    check("n15_pulses", (n_init - b_init) + (n_next - b_next), 8);
    check("n15_done_cycle", last_done - s, 42);

    // abort during block-3 WAIT (F=0, R=3: blocks are 8 cycles long)
    b_done = n_done;
    start_job(8, 0, 3, s);
    while (cyc < s + 29) tick();
    abort = 1'b1;
    exp_q.delete();
    tick();
    abort = 1'b0;
    check("abort_idle", 32'(actual()), 0);
    tick(); tick();
    check("abort_no_done", n_done - b_done, 0);
    b_done = n_done;
    start_job(2, 0, 0, s);
    drain();
    check("after_abort_done", n_done - b_done, 1);

    // start and abort together in IDLE: stays idle
    start = 1'b1; abort = 1'b1; num_blocks = 4'd2;
    tick();
    start = 1'b0; abort = 1'b0;
    check("start_abort_idle", 32'(actual()), 0);
    tick();

    // start held through a job: restart only from IDLE
    b_done = n_done;
    f_lat = 0; r_lat = 0;
    num_blocks = 4'd1;
    start = 1'b1;
    s = cyc;
    dflt = '0;
    push_job(1, 0, 0);
    exp_q.push_back('0);
    push_job(1, 0, 0);
    while (cyc < s + 9) tick();
    start = 1'b0;
    drain();
    check("held_start_dones", n_done - b_done, 2);

    // asynchronous reset in the middle of FETCH
    start_job(2, 5, 0, s);
    while (cyc < s + 3) tick();
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("async_reset_outputs", 32'(actual()), 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    b_done = n_done;
    start_job(1, 0, 0, s);
    drain();
    check("after_reset_done", n_done - b_done, 1);

`ifdef HASH_SEQ_TIMEOUT_EN
    // core never ready: ERR after TMO wait cycles, then restart from ERR
    start_job(1, 0, 1000000, s);
    drain();
    tick();
    check("wdog_err", err, 1);
    check("wdog_busy", busy, 0);
    b_done = n_done;
    start_job(1, 0, 0, s);
    check("wdog_err_cleared", err, 0);
    drain();
    check("wdog_restart_done", n_done - b_done, 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "timeout");
  end

endmodule
